// File: rtl/tlc_pkg.sv
// Shared lamp codes, phase type and default dwell times
// for the traffic-light controller monitor.
package tlc_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef logic [2:0] phase_t;

  localparam int TG_DEF = 12;
  localparam int TY_DEF = 3;

  function automatic phase_t next_phase(phase_t p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational map from the four lamp codes to a phase
// number, with dark and multiple-green detection.
module tlc_lamp_decode
  import tlc_pkg::*;
(
  input  logic [2:0] north,
  input  logic [2:0] east,
  input  logic [2:0] south,
  input  logic [2:0] west,
  output phase_t     phase,
  output logic       valid,
  output logic       dark,
  output logic       multi_green
);

  logic [3:0] grn;

  assign grn = {north == GRN, east == GRN,
                south == GRN, west == GRN};
  assign multi_green = (grn & (grn - 4'd1)) != 4'd0;
  assign dark = {north, east, south, west} == 12'd0;

  always_comb begin
    phase = 3'd0;
    valid = 1'b0;
    case ({north, east, south, west})
      {GRN, RED, RED, RED}: begin phase = 3'd0; valid = 1'b1; end
      {YEL, YEL, RED, RED}: begin phase = 3'd1; valid = 1'b1; end
      {RED, GRN, RED, RED}: begin phase = 3'd2; valid = 1'b1; end
      {RED, YEL, YEL, RED}: begin phase = 3'd3; valid = 1'b1; end
      {RED, RED, GRN, RED}: begin phase = 3'd4; valid = 1'b1; end
      {RED, RED, YEL, YEL}: begin phase = 3'd5; valid = 1'b1; end
      {RED, RED, RED, GRN}: begin phase = 3'd6; valid = 1'b1; end
      {YEL, RED, RED, YEL}: begin phase = 3'd7; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tlc_monitor.sv
// Traffic-light sequence/encoding/timing monitor with sticky flags.
// Dwell-time checking is built only with TLC_MON_TIMING_EN defined.
module tlc_monitor
  import tlc_pkg::*;
#(
  parameter int TG = TG_DEF,
  parameter int TY = TY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north,
  input  logic [2:0] east,
  input  logic [2:0] south,
  input  logic [2:0] west,
  input  logic       err_clr,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic       err_conflict,
  output logic       err_encoding,
  output logic       err_sequence,
  output logic       err_timing,
  output logic       fault,
  output logic [7:0] rot_count
);

  logic [11:0] lamp_d, lamp_q;
  phase_t      dec_phase;
  logic        dec_valid, dec_dark, dec_multi;

  phase_t      phase_d, phase_q;
  logic        valid_d, valid_q;
  logic        tracked_d, tracked_q;
  logic [7:0]  rot_d, rot_q;
  logic        conf_d, conf_q, enc_d, enc_q;
  logic        seq_d, seq_q, tim_d, tim_q;
  logic        fault_d, fault_q;
  logic        new_conf, new_enc, new_seq, new_tim;
  logic        chg;

  assign lamp_d = {north, east, south, west};

  tlc_lamp_decode u_dec (
    .north       (lamp_q[11:9]),
    .east        (lamp_q[8:6]),
    .south       (lamp_q[5:3]),
    .west        (lamp_q[2:0]),
    .phase       (dec_phase),
    .valid       (dec_valid),
    .dark        (dec_dark),
    .multi_green (dec_multi)
  );

  assign chg = tracked_q & dec_valid & (dec_phase != phase_q);

  always_comb begin
    phase_d   = phase_q;
    valid_d   = 1'b0;
    tracked_d = 1'b0;
    rot_d     = rot_q;
    new_conf  = 1'b0;
    new_enc   = 1'b0;
    new_seq   = 1'b0;
    if (dec_dark) begin
      tracked_d = 1'b0;
    end else if (!dec_valid) begin
      new_enc  = 1'b1;
      new_conf = dec_multi;
    end else begin
      valid_d   = 1'b1;
      tracked_d = 1'b1;
      phase_d   = dec_phase;
      if (chg && dec_phase != next_phase(phase_q))
        new_seq = 1'b1;
      if (chg && phase_q == 3'd7 && dec_phase == 3'd0)
        rot_d = rot_q + 8'd1;
    end
    // a fresh detection outranks a same-cycle clear
    conf_d  = (conf_q & ~err_clr) | new_conf;
    enc_d   = (enc_q  & ~err_clr) | new_enc;
    seq_d   = (seq_q  & ~err_clr) | new_seq;
    tim_d   = (tim_q  & ~err_clr) | new_tim;
    fault_d = conf_q | enc_q | seq_q | tim_q;
  end

`ifdef TLC_MON_TIMING_EN
  localparam logic [7:0] TG_L = 8'(TG);
  localparam logic [7:0] TY_L = 8'(TY);

  logic [7:0] dwell_d, dwell_q, lim;
  logic       exempt_d, exempt_q;

  assign lim = phase_q[0] ? TY_L : TG_L;

  always_comb begin
    dwell_d  = 8'd0;
    exempt_d = 1'b1;
    new_tim  = 1'b0;
    if (dec_valid && !tracked_q) begin
      dwell_d = 8'd1;
    end else if (dec_valid && !chg) begin
      dwell_d  = (&dwell_q) ? dwell_q : dwell_q + 8'd1;
      exempt_d = exempt_q;
      new_tim  = !exempt_q && (dwell_d > lim);
    end else if (chg) begin
      dwell_d  = 8'd1;
      exempt_d = 1'b0;
      new_tim  = !exempt_q && (dwell_q != lim);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_q  <= 8'd0;
      exempt_q <= 1'b1;
    end else begin
      dwell_q  <= dwell_d;
      exempt_q <= exempt_d;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(TG + TY);
  assign new_tim    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      lamp_q    <= 12'd0;
      phase_q   <= 3'd0;
      valid_q   <= 1'b0;
      tracked_q <= 1'b0;
      rot_q     <= 8'd0;
      conf_q    <= 1'b0;
      enc_q     <= 1'b0;
      seq_q     <= 1'b0;
      tim_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      lamp_q    <= lamp_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      tracked_q <= tracked_d;
      rot_q     <= rot_d;
      conf_q    <= conf_d;
      enc_q     <= enc_d;
      seq_q     <= seq_d;
      tim_q     <= tim_d;
      fault_q   <= fault_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = valid_q;
  assign err_conflict = conf_q;
  assign err_encoding = enc_q;
  assign err_sequence = seq_q;
  assign err_timing   = tim_q;
  assign fault        = fault_q;
  assign rot_count    = rot_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed bench for tlc_monitor: legal rotation, conflict,
// skip, dwell timing, reset/dark, encoding and clear priority.
module tb_tlc_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
`ifdef TLC_MON_TIMING_EN
  localparam logic TIM = 1'b1;
`else
  localparam logic TIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] north, east, south, west;
  logic       err_clr;
  logic [2:0] phase;
  logic       phase_valid;
  logic       err_conflict, err_encoding;
  logic       err_sequence, err_timing;
  logic       fault;
  logic [7:0] rot_count;

  int n_chk  = 0;
  int n_fail = 0;
  int p, d;

  always #5 clk = ~clk;

  tlc_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .north        (north),
    .east         (east),
    .south        (south),
    .west         (west),
    .err_clr      (err_clr),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .err_conflict (err_conflict),
    .err_encoding (err_encoding),
    .err_sequence (err_sequence),
    .err_timing   (err_timing),
    .fault        (fault),
    .rot_count    (rot_count)
  );

  function automatic logic [11:0] pat(int ph);
    case (ph)
      0: return {G, R, R, R};
      1: return {Y, Y, R, R};
      2: return {R, G, R, R};
      3: return {R, Y, Y, R};
      4: return {R, R, G, R};
      5: return {R, R, Y, Y};
      6: return {R, R, R, G};
      7: return {Y, R, R, Y};
      default: return 12'd0;
    endcase
  endfunction

  function automatic logic [31:0] flags();
    return {28'd0, err_conflict, err_encoding,
            err_sequence, err_timing};
  endfunction

  task automatic drive(input logic [11:0] v);
    {north, east, south, west} = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    err_clr = 1'b0;
    drive(12'd0);
    tick(3);
    check("rst_phase", 32'(phase), 0);
    check("rst_valid", 32'(phase_valid), 0);
    check("rst_flags", flags(), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_rot", 32'(rot_count), 0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      p = i % 8;
      d = (p % 2 == 0) ? 12 : 3;
      drive(pat(p));
      tick(1);
      if (i > 0) check("lat_hold", 32'(phase), (p + 7) % 8);
      tick(1);
      check("lat_phase", 32'(phase), p);
      check("lat_valid", 32'(phase_valid), 1);
      tick(d - 2);
    end
    check("cyc_flags", flags(), 0);
    check("cyc_rot", 32'(rot_count), 2);
    check("cyc_fault", 32'(fault), 0);
    drive(12'd0);
    tick(3);
    check("dark_valid", 32'(phase_valid), 0);
    check("dark_flags", flags(), 0);

    drive({G, G, R, R});
    tick(1);
    drive(12'd0);
    tick(1);
    check("gg_conf", 32'(err_conflict), 1);
    check("gg_enc", 32'(err_encoding), 1);
    check("gg_valid", 32'(phase_valid), 0);
    check("gg_fault_lag", 32'(fault), 0);
    tick(1);
    check("gg_fault", 32'(fault), 1);
    clr_pulse();
    check("gg_clr", flags(), 0);
    tick(1);
    check("gg_fault_clr", 32'(fault), 0);

    drive(pat(2));
    tick(12);
    drive(pat(4));
    tick(1);
    check("skip_pre", 32'(err_sequence), 0);
    tick(1);
    check("skip_seq", 32'(err_sequence), 1);
    check("skip_tim", 32'(err_timing), 0);
    check("skip_phase", 32'(phase), 4);
    drive(12'd0);
    tick(2);
    clr_pulse();
    check("skip_clr", flags(), 0);

    drive(pat(3));
    tick(3);
    drive(pat(4));
    tick(11);
    drive(pat(5));
    tick(1);
    check("sg_pre", 32'(err_timing), 0);
    tick(1);
    check("sg_tim", 32'(err_timing), 32'(TIM));
    check("sg_seq", 32'(err_sequence), 0);
    clr_pulse();
    check("ly_clr", 32'(err_timing), 0);
    tick(1);
    check("ly_3", 32'(err_timing), 0);
    drive(pat(6));
    tick(1);
    check("ly_tim", 32'(err_timing), 32'(TIM));
    drive(12'd0);
    tick(3);
    clr_pulse();
    check("tim_clr", flags(), 0);

    drive(pat(1));
    tick(3);
    drive(pat(2));
    tick(5);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(7);
    check("mr_valid", 32'(phase_valid), 1);
    check("mr_phase", 32'(phase), 2);
    check("mr_flags", flags(), 0);
    check("mr_rot", 32'(rot_count), 0);
    check("mr_fault", 32'(fault), 0);

    drive({R, R, R, 3'b011});
    tick(2);
    check("enc_enc", 32'(err_encoding), 1);
    check("enc_conf", 32'(err_conflict), 0);
    check("enc_valid", 32'(phase_valid), 0);
    check("enc_phase", 32'(phase), 2);
    drive(12'd0);
    tick(2);

    drive(pat(0));
    tick(3);
    drive(pat(2));
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("cs_seq", 32'(err_sequence), 1);
    check("cs_enc", 32'(err_encoding), 0);
    tick(1);
    check("cs_fault", 32'(fault), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_monitor.md
TLC_MONITOR -- requirements
Module: tlc_monitor

Interface
REQ-001 Parameter TG, default 12, required green dwell in clock cycles.
REQ-002 Parameter TY, default 3, required yellow dwell in clock cycles.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 north, east, south, west  input  3 each  lamp codes: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-006 err_clr  input  1  single-cycle pulse that clears all sticky error flags.
REQ-007 phase  output  3  decoded current phase, 0-7.
REQ-008 phase_valid  output  1  high when the current lamp pattern matches a legal phase.
REQ-009 err_conflict, err_encoding, err_sequence, err_timing  output  1 each  sticky error flags.
REQ-010 fault  output  1  OR of the four sticky flags, registered.
REQ-011 rot_count  output  8  count of completed full rotations, wrapping.

Function
REQ-012 Lamp inputs shall be registered once on entry; all outputs shall be registered from that sample, so a pattern present before edge k appears on the outputs after edge k+1 (latency 2).
REQ-013 The legal phases (lamps listed as N/E/S/W) shall be:
- 0: G/R/R/R
- 1: Y/Y/R/R
- 2: R/G/R/R
- 3: R/Y/Y/R
- 4: R/R/G/R
- 5: R/R/Y/Y
- 6: R/R/R/G
- 7: Y/R/R/Y
REQ-014 All four lamps 3'b000 shall be treated as "dark":
- phase_valid=0, no error raised.
- Sequence and timing tracking return to the untracked state.
REQ-015 Any non-dark pattern not in the REQ-013 table shall set err_encoding and drive phase_valid=0; phase holds its last value.
REQ-016 Two or more green lamps in one sample shall set err_conflict (err_encoding is also set).
REQ-017 Each sample shall increment a saturating 8-bit dwell counter while the phase is unchanged; the counter restarts at 1 on a phase change.
REQ-018 Each phase change from valid phase p shall require the new phase to equal (p+1) mod 8; otherwise it shall set err_sequence.
REQ-019 Timing check on a phase change: the completed phase's dwell shall equal TG (even phases) or TY (odd phases); otherwise it shall set err_timing.
REQ-020 Timing check within a phase: a dwell reaching TG+1 or TY+1 shall set err_timing immediately.
REQ-021 The first phase observed after reset, dark, or an invalid pattern shall be exempt from timing checks (partial dwell); sequence checking resumes from that phase.
REQ-022 A legal transition 7 to 0 shall increment rot_count, wrapping 255 to 0.
REQ-023 err_clr shall clear all sticky flags; a new error detected in the same cycle shall win and leave its flag set.
REQ-024 fault shall follow the flags with one extra cycle of latency.

Reset
REQ-025 While rst=0 at a clock edge, the block shall set:
- phase=0, phase_valid=0, all flags=0, fault=0, rot_count=0.
- Dwell counter=0, tracking untracked.
REQ-026 Reset asserted mid-phase shall abandon the partial dwell with no error raised.

Configuration
REQ-027 With macro TLC_MON_TIMING_EN defined, REQ-017, REQ-019, REQ-020 and REQ-021 shall be implemented.
REQ-028 Without TLC_MON_TIMING_EN, err_timing shall be constant 0, no dwell counter shall be built, and all other checks shall be unchanged.

Structure
REQ-029 Shared package tlc_pkg shall hold:
- Lamp code constants RED, YEL, GRN.
- The 3-bit phase type.
- Default TG and TY.
REQ-030 Pattern-to-phase decode shall be a combinational sub-module tlc_lamp_decode with outputs phase, valid, dark and multi_green.

Verification
REQ-031 Legal cycle: phases 0..7 at dwells 12/3 repeated twice -> no flags set, rot_count=2, phase tracks the input 2 cycles late.
REQ-032 Two greens: N=G, E=G for 1 cycle -> err_conflict=1, err_encoding=1, fault=1 one cycle after the flags; err_clr then returns all to 0.
REQ-033 Skip: phase 2 followed directly by phase 4 -> err_sequence=1, err_timing unaffected.
REQ-034 Short green: phase 4 held 11 cycles -> err_timing set on the change. Long yellow: phase 5 held 4 cycles -> err_timing set on the 4th sample.
REQ-035 Reset/dark: rst low mid-phase 2, then phase 2 held 7 cycles -> no error. Separately, 3'b011 on west -> err_encoding=1, phase_valid=0.
REQ-036 err_clr asserted in the same cycle as a new sequence error -> err_sequence remains 1.
